// File: rtl/qs_pkg.sv
// Shared types and constants for the quicksort enqueue front end.
// Optional feature macro used by qs_enq_mb: QS_ENQ_SOP_RESYNC_EN.
package qs_pkg;

  localparam int QS_W         = 32;
  localparam int QS_N         = 16;
  localparam int QS_BANKS_N   = 2;
  localparam int QS_ADDR_W    = $clog2(QS_N);
  localparam int QS_BANK_ID_W = (QS_BANKS_N > 1) ? $clog2(QS_BANKS_N) : 1;

  typedef logic [QS_W-1:0]         w_t;
  typedef logic [QS_ADDR_W-1:0]    addr_t;
  typedef logic [QS_BANK_ID_W-1:0] bank_id_t;

  typedef enum logic [1:0] {
    BANK_IDLE    = 2'd0,
    BANK_LOADING = 2'd1,
    BANK_READY   = 2'd2,
    BANK_SORTING = 2'd3
  } bank_status_t;

  // Scoreboard entry for one bank; n is the index of the last valid entry.
  typedef struct packed {
    bank_status_t status;
    logic         err;
    addr_t        n;
  } bank_state_t;

  // Enqueue FSM encoding: bit 2 is the input-ready bit, so the ready output
  // is taken straight from the state flop.
  localparam logic [2:0] ST_IDLE   = 3'b000;
  localparam logic [2:0] ST_SETTLE = 3'b001;
  localparam logic [2:0] ST_LOAD   = 3'b100;
  localparam logic [2:0] ST_DRAIN  = 3'b101;

  // Next bank id with wrap at QS_BANKS_N-1.
  function automatic bank_id_t bank_id_inc(input bank_id_t id);
    return (id == bank_id_t'(QS_BANKS_N - 1)) ? '0 : bank_id_t'(id + 1'b1);
  endfunction

endpackage

// File: rtl/qs_enq_bank_rr.sv
// Round-robin bank pointer: advances by one on adv, wrapping BANKS_N-1 -> 0.
module qs_enq_bank_rr #(
  parameter  int BANKS_N   = 2,
  localparam int BANK_ID_W = (BANKS_N > 1) ? $clog2(BANKS_N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 adv,
  output logic [BANK_ID_W-1:0] idx_r
);

  // Bank pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r <= '0;
    end else if (adv) begin
      idx_r <= (idx_r == BANK_ID_W'(BANKS_N - 1)) ? '0 : idx_r + 1'b1;
    end
  end

endmodule

// File: rtl/qs_enq_mb.sv
// Multi-bank enqueue front end: claims the selected bank, streams one
// sop..eop packet into it, publishes READY, then moves to the next bank.
// Packets longer than N entries are truncated and drained with err set.
// Optional macro QS_ENQ_SOP_RESYNC_EN: hunt for sop at packet start and
// restart the packet on any later sop.
module qs_enq_mb
  import qs_pkg::*;
#(
  parameter  int W         = QS_W,
  parameter  int N         = QS_N,
  parameter  int BANKS_N   = QS_BANKS_N,
  localparam int ADDR_W    = $clog2(N),
  localparam int BANK_ID_W = (BANKS_N > 1) ? $clog2(BANKS_N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_vld,
  input  logic                 in_sop,
  input  logic                 in_eop,
  input  logic [W-1:0]         in_dat,
  output logic                 in_rdy_r,
  output logic [BANK_ID_W-1:0] bank_idx_r,
  input  bank_state_t          bank_in_r,
  output logic                 bank_out_vld_r,
  output bank_state_t          bank_out_r,
  output logic                 wr_en_r,
  output logic [ADDR_W-1:0]    wr_addr_r,
  output logic [W-1:0]         wr_data_r
);

  logic [2:0]        state_r;
  logic [ADDR_W-1:0] idx_r;
  logic              err_r;

  logic              accept;
  logic              sop_restart;
  logic              hunt_drop;
  logic [ADDR_W-1:0] wr_idx;
  logic              load_beat;
  logic              drain_eop;
  logic              unused_inputs;

  assign in_rdy_r = state_r[2];
  assign accept   = in_vld & in_rdy_r;

`ifdef QS_ENQ_SOP_RESYNC_EN
  assign sop_restart   = in_sop;
  assign hunt_drop     = (idx_r == '0) & ~in_sop;
  assign unused_inputs = ^{bank_in_r.err, bank_in_r.n};
`else
  assign sop_restart   = 1'b0;
  assign hunt_drop     = 1'b0;
  assign unused_inputs = ^{bank_in_r.err, bank_in_r.n, in_sop};
`endif

  // A restarting sop always lands at address 0.
  assign wr_idx    = sop_restart ? '0 : idx_r;
  assign load_beat = accept & (((state_r == ST_LOAD)  & ~hunt_drop) |
                               ((state_r == ST_DRAIN) &  sop_restart));
  assign drain_eop = accept & (state_r == ST_DRAIN) & ~sop_restart & in_eop;

  // Bank pointer advances during the SETTLE bubble.
  qs_enq_bank_rr #(
    .BANKS_N (BANKS_N)
  ) u_bank_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (state_r == ST_SETTLE),
    .idx_r (bank_idx_r)
  );

  // Enqueue FSM plus registered memory and scoreboard write ports.
  // NOTE: no memory lives here, so every flop is reset; strobes default low
  // each cycle and are raised only by the branch that needs them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      idx_r          <= '0;
      err_r          <= 1'b0;
      bank_out_vld_r <= 1'b0;
      bank_out_r     <= '0;
      wr_en_r        <= 1'b0;
      wr_addr_r      <= '0;
      wr_data_r      <= '0;
    end else begin
      wr_en_r        <= 1'b0;
      bank_out_vld_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bank_in_r.status == BANK_IDLE) begin
            bank_out_vld_r <= 1'b1;
            bank_out_r     <= '{status: BANK_LOADING, err: 1'b0, n: '0};
            wr_addr_r      <= '0;
            idx_r          <= '0;
            err_r          <= 1'b0;
            state_r        <= ST_LOAD;
          end
        end
        ST_LOAD, ST_DRAIN: begin
          if (load_beat) begin
            wr_en_r   <= 1'b1;
            wr_data_r <= in_dat;
            wr_addr_r <= wr_idx;
            idx_r     <= wr_idx + 1'b1;
            err_r     <= 1'b0;
            state_r   <= ST_LOAD;
            if (in_eop) begin
              bank_out_vld_r <= 1'b1;
              bank_out_r     <= '{status: BANK_READY, err: 1'b0, n: addr_t'(wr_idx)};
              state_r        <= ST_SETTLE;
            end else if (wr_idx == ADDR_W'(N - 1)) begin
              err_r   <= 1'b1;
              state_r <= ST_DRAIN;
            end
          end else if (drain_eop) begin
            bank_out_vld_r <= 1'b1;
            bank_out_r     <= '{status: BANK_READY, err: err_r, n: addr_t'(N - 1)};
            state_r        <= ST_SETTLE;
          end
        end
        ST_SETTLE: state_r <= ST_IDLE;
        default:   state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qs_enq_mb.sv
// Directed bench for qs_enq_mb with a two-bank scoreboard model that the
// bench frees by hand to emulate the sorter consuming READY banks.
module tb_qs_enq_mb;
  import qs_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_vld, in_sop, in_eop;
  logic [31:0] in_dat;
  logic        in_rdy_r;
  logic [0:0]  bank_idx_r;
  bank_state_t bank_in_r;
  logic        bank_out_vld_r;
  bank_state_t bank_out_r;
  logic        wr_en_r;
  logic [3:0]  wr_addr_r;
  logic [31:0] wr_data_r;

  int n_cmp = 0;
  int n_err = 0;

  bank_state_t sb [2];
  logic [1:0]  free_tgl = 2'b00;
  logic [1:0]  free_seen;
  logic [35:0] wr_q [$];
  logic [7:0]  sb_q [$];
  int          wr_base, sb_base;

  always #5 clk = ~clk;

  qs_enq_mb dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_vld         (in_vld),
    .in_sop         (in_sop),
    .in_eop         (in_eop),
    .in_dat         (in_dat),
    .in_rdy_r       (in_rdy_r),
    .bank_idx_r     (bank_idx_r),
    .bank_in_r      (bank_in_r),
    .bank_out_vld_r (bank_out_vld_r),
    .bank_out_r     (bank_out_r),
    .wr_en_r        (wr_en_r),
    .wr_addr_r      (wr_addr_r),
    .wr_data_r      (wr_data_r)
  );

  assign bank_in_r = sb[bank_idx_r];

  // Scoreboard, write logger and bank-free requests (toggle handshake).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb[0]     <= '0;
      sb[1]     <= '0;
      free_seen <= free_tgl;
    end else begin
      if (wr_en_r) wr_q.push_back({wr_addr_r, wr_data_r});
      if (bank_out_vld_r) begin
        sb[bank_idx_r] <= bank_out_r;
        sb_q.push_back({bank_idx_r, bank_out_r});
      end
      for (int i = 0; i < 2; i++) begin
        if (free_tgl[i] != free_seen[i]) begin
          sb[i].status <= BANK_IDLE;
          free_seen[i] <= free_tgl[i];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sbe(input logic idx, input bank_status_t st,
                                     input logic err, input logic [3:0] n);
    return {idx, st, err, n};
  endfunction

  // Present one beat at a negedge and hold it until accepted.
  task automatic beat(input logic sop, input logic eop, input logic [31:0] d);
    int budget = 60;
    in_vld = 1'b1; in_sop = sop; in_eop = eop; in_dat = d;
    while (!in_rdy_r && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check("beat_timeout_rdy", in_rdy_r, 1);
    @(negedge clk);
    in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_dat = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rdy",     in_rdy_r, 0);
    check("rst_wr_en",   wr_en_r, 0);
    check("rst_sb_vld",  bank_out_vld_r, 0);
    check("rst_idx",     bank_idx_r, 0);
    check("rst_wr_addr", wr_addr_r, 0);
    check("rst_wr_data", wr_data_r, 0);
    check("rst_sb_out",  bank_out_r, 0);

    // Claim of bank 0 right after reset release.
    wr_base = wr_q.size(); sb_base = sb_q.size();
    rst_n = 1'b1;
    @(negedge clk);
    check("claim_vld", bank_out_vld_r, 1);
    check("claim_val", bank_out_r, {BANK_LOADING, 1'b0, 4'd0});
    check("claim_rdy", in_rdy_r, 1);

    // 4-beat packet with a bubble in the middle.
    beat(1, 0, 32'hA); beat(0, 0, 32'hB);
    repeat (2) @(negedge clk);
    beat(0, 0, 32'hC); beat(0, 1, 32'hD);
    repeat (4) @(negedge clk);
    check("t1_wr_cnt", wr_q.size() - wr_base, 4);
    check("t1_wr0", wr_q[wr_base+0], {4'd0, 32'hA});
    check("t1_wr1", wr_q[wr_base+1], {4'd1, 32'hB});
    check("t1_wr2", wr_q[wr_base+2], {4'd2, 32'hC});
    check("t1_wr3", wr_q[wr_base+3], {4'd3, 32'hD});
    check("t1_sb_cnt", sb_q.size() - sb_base, 3);
    check("t1_sb0", sb_q[sb_base+0], sbe(0, BANK_LOADING, 0, 0));
    check("t1_sb1", sb_q[sb_base+1], sbe(0, BANK_READY, 0, 3));
    check("t1_sb2", sb_q[sb_base+2], sbe(1, BANK_LOADING, 0, 0));
    check("t1_idx", bank_idx_r, 1);

    // Three 1-beat packets; the third stalls on bank 1 still READY.
    wr_base = wr_q.size(); sb_base = sb_q.size();
    free_tgl[0] = ~free_tgl[0];
    beat(1, 1, 32'h11);
    beat(1, 1, 32'h22);
    in_vld = 1'b1; in_sop = 1'b1; in_eop = 1'b1; in_dat = 32'h33;
    repeat (6) @(negedge clk);
    check("t2_stall_rdy", in_rdy_r, 0);
    check("t2_stall_idx", bank_idx_r, 1);
    check("t2_stall_wr_cnt", wr_q.size() - wr_base, 2);
    free_tgl[1] = ~free_tgl[1];
    beat(1, 1, 32'h33);
    repeat (4) @(negedge clk);
    check("t2_wr_cnt", wr_q.size() - wr_base, 3);
    check("t2_wr0", wr_q[wr_base+0], {4'd0, 32'h11});
    check("t2_wr1", wr_q[wr_base+1], {4'd0, 32'h22});
    check("t2_wr2", wr_q[wr_base+2], {4'd0, 32'h33});
    check("t2_sb_cnt", sb_q.size() - sb_base, 5);
    check("t2_sb0", sb_q[sb_base+0], sbe(1, BANK_READY, 0, 0));
    check("t2_sb1", sb_q[sb_base+1], sbe(0, BANK_LOADING, 0, 0));
    check("t2_sb2", sb_q[sb_base+2], sbe(0, BANK_READY, 0, 0));
    check("t2_sb3", sb_q[sb_base+3], sbe(1, BANK_LOADING, 0, 0));
    check("t2_sb4", sb_q[sb_base+4], sbe(1, BANK_READY, 0, 0));

    // 20-beat packet into bank 0: 16 writes, 4 drained, err set.
    wr_base = wr_q.size(); sb_base = sb_q.size();
    free_tgl[0] = ~free_tgl[0];
    for (int i = 0; i < 20; i++) beat(i == 0, i == 19, 32'h100 + i);
    repeat (4) @(negedge clk);
    check("t3_wr_cnt", wr_q.size() - wr_base, 16);
    for (int i = 0; i < 16; i++)
      check($sformatf("t3_wr%0d", i), wr_q[wr_base+i], {i[3:0], 32'h100 + i});
    check("t3_sb_cnt", sb_q.size() - sb_base, 2);
    check("t3_sb0", sb_q[sb_base+0], sbe(0, BANK_LOADING, 0, 0));
    check("t3_sb1", sb_q[sb_base+1], sbe(0, BANK_READY, 1, 15));
    check("t3_idx", bank_idx_r, 1);

    // Reset after beat 2 of a packet into bank 1.
    free_tgl[1] = ~free_tgl[1];
    beat(1, 0, 32'h301); beat(0, 0, 32'h302);
    rst_n = 1'b0;
    #1;
    check("t5_rdy",     in_rdy_r, 0);
    check("t5_wr_en",   wr_en_r, 0);
    check("t5_sb_vld",  bank_out_vld_r, 0);
    check("t5_idx",     bank_idx_r, 0);
    check("t5_wr_addr", wr_addr_r, 0);
    check("t5_wr_data", wr_data_r, 0);
    check("t5_sb_out",  bank_out_r, 0);
    @(negedge clk);
    wr_base = wr_q.size(); sb_base = sb_q.size();
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_reclaim_vld", bank_out_vld_r, 1);

    // Exactly 16 beats into bank 0: normal completion at index N-1.
    for (int i = 0; i < 16; i++) beat(i == 0, i == 15, 32'h200 + i);
    repeat (4) @(negedge clk);
    check("t4_wr_cnt", wr_q.size() - wr_base, 16);
    check("t4_wr0",  wr_q[wr_base+0],  {4'd0,  32'h200});
    check("t4_wr15", wr_q[wr_base+15], {4'd15, 32'h20F});
    check("t4_sb_cnt", sb_q.size() - sb_base, 3);
    check("t4_sb0", sb_q[sb_base+0], sbe(0, BANK_LOADING, 0, 0));
    check("t4_sb1", sb_q[sb_base+1], sbe(0, BANK_READY, 0, 15));
    check("t4_sb2", sb_q[sb_base+2], sbe(1, BANK_LOADING, 0, 0));
    check("t4_idx", bank_idx_r, 1);

`ifdef QS_ENQ_SOP_RESYNC_EN
    // sop on beat 3 restarts the packet at address 0.
    wr_base = wr_q.size(); sb_base = sb_q.size();
    beat(1, 0, 32'h401); beat(0, 0, 32'h402); beat(1, 0, 32'h403);
    beat(0, 0, 32'h404); beat(0, 1, 32'h405);
    repeat (4) @(negedge clk);
    check("t6_wr_cnt", wr_q.size() - wr_base, 5);
    check("t6_wr2", wr_q[wr_base+2], {4'd0, 32'h403});
    check("t6_wr3", wr_q[wr_base+3], {4'd1, 32'h404});
    check("t6_wr4", wr_q[wr_base+4], {4'd2, 32'h405});
    check("t6_sb0", sb_q[sb_base+0], sbe(1, BANK_READY, 0, 2));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
